// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types and constants for the GPR write-back arbiter.
// Register index/data widths, requester ids and rs_use bit positions.
package gpr_wb_arbiter_pkg;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_GPR        = 2 ** GPR_ADDR_WIDTH;

  localparam logic REQ_EXU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int RS1_USE = 0;
  localparam int RS2_USE = 1;

  typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;
  typedef logic [DATA_WIDTH-1:0]     gpr_data_t;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Write-back, issue and GPR write-port signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface gpr_wb_arbiter_if;
  import gpr_wb_arbiter_pkg::*;

  logic        exu_wb_valid;
  logic        exu_wb_ready;
  gpr_addr_t   exu_wb_rd;
  gpr_data_t   exu_wb_data;

  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  gpr_addr_t   lsu_wb_rd;
  gpr_data_t   lsu_wb_data;

  logic        issue_valid;
  logic        issue_ready;
  logic        issue_rd_wen;
  gpr_addr_t   issue_rd;
  logic [1:0]  issue_rs_use;
  gpr_addr_t   issue_rs1;
  gpr_addr_t   issue_rs2;
  logic        hazard_stall;

  logic        gpr_wen;
  gpr_addr_t   gpr_waddr;
  gpr_data_t   gpr_wdata;

  modport master (
    output exu_wb_valid, exu_wb_rd, exu_wb_data,
    input  exu_wb_ready,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  lsu_wb_ready,
    output issue_valid, issue_rd_wen, issue_rd,
    output issue_rs_use, issue_rs1, issue_rs2,
    input  issue_ready, hazard_stall,
    input  gpr_wen, gpr_waddr, gpr_wdata
  );

  modport slave (
    input  exu_wb_valid, exu_wb_rd, exu_wb_data,
    output exu_wb_ready,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output lsu_wb_ready,
    input  issue_valid, issue_rd_wen, issue_rd,
    input  issue_rs_use, issue_rs1, issue_rs2,
    output issue_ready, hazard_stall,
    output gpr_wen, gpr_waddr, gpr_wdata
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits for in-flight GPR writes.
// x0 never becomes pending; a set and clear of one entry at one edge keeps it set.
module gpr_scoreboard
  import gpr_wb_arbiter_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      set_en_i,
  input  gpr_addr_t set_idx_i,
  input  logic      clr_en_i,
  input  gpr_addr_t clr_idx_i,
  input  gpr_addr_t rs1_idx_i,
  input  gpr_addr_t rs2_idx_i,
  input  gpr_addr_t rd_idx_i,
  output logic      rs1_pend_o,
  output logic      rs2_pend_o,
  output logic      rd_pend_o
);

  logic [NUM_GPR-1:0] pend_q;
  logic [NUM_GPR-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign rs1_pend_o = pend_q[rs1_idx_i];
  assign rs2_pend_o = pend_q[rs2_idx_i];
  assign rd_pend_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin EXU/LSU write-back arbiter owning the GPR write port,
// with a pending scoreboard that stalls issue on RAW/WAW hazards.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
(
  input logic              clk,
  input logic              rst,
  gpr_wb_arbiter_if.slave  bus
);

  logic      ptr_q, ptr_d;
  logic      wen_q, wen_d;
  gpr_addr_t waddr_q, waddr_d;
  gpr_data_t wdata_q, wdata_d;

  logic      contest;
  logic      exu_win;
  logic      lsu_win;
  logic      hs;
  gpr_addr_t win_rd;
  gpr_data_t win_data;

  logic      rs1_pend;
  logic      rs2_pend;
  logic      rd_pend;
  logic      issue_ok;
  logic      sb_set;

  assign contest = bus.exu_wb_valid & bus.lsu_wb_valid;
  assign exu_win = bus.exu_wb_valid &
                   (~bus.lsu_wb_valid | (ptr_q == REQ_EXU));
  assign lsu_win = bus.lsu_wb_valid &
                   (~bus.exu_wb_valid | (ptr_q == REQ_LSU));
  assign hs      = exu_win | lsu_win;

  assign bus.exu_wb_ready = exu_win;
  assign bus.lsu_wb_ready = lsu_win;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    unique case (1'b1)
      exu_win: begin
        win_rd   = bus.exu_wb_rd;
        win_data = bus.exu_wb_data;
      end
      lsu_win: begin
        win_rd   = bus.lsu_wb_rd;
        win_data = bus.lsu_wb_data;
      end
      default: ;
    endcase
  end

  // Only a contested grant hands priority to the loser.
  always_comb begin
    ptr_d   = contest ? ~ptr_q : ptr_q;
    wen_d   = hs & (win_rd != '0);
    waddr_d = hs ? win_rd : waddr_q;
    wdata_d = hs ? win_data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= REQ_EXU;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.gpr_wen   = wen_q;
  assign bus.gpr_waddr = waddr_q;
  assign bus.gpr_wdata = wdata_q;

  assign issue_ok =
    ~((bus.issue_rs_use[RS1_USE] & rs1_pend) |
      (bus.issue_rs_use[RS2_USE] & rs2_pend) |
      (bus.issue_rd_wen & rd_pend));

  assign sb_set = bus.issue_valid & issue_ok &
                  bus.issue_rd_wen & (bus.issue_rd != '0);

  assign bus.issue_ready  = issue_ok;
  assign bus.hazard_stall = bus.issue_valid & ~issue_ok;

  // Pending clears at the edge the GPR captures the write.
  gpr_scoreboard u_sb (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (sb_set),
    .set_idx_i  (bus.issue_rd),
    .clr_en_i   (wen_q),
    .clr_idx_i  (waddr_q),
    .rs1_idx_i  (bus.issue_rs1),
    .rs2_idx_i  (bus.issue_rs2),
    .rd_idx_i   (bus.issue_rd),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .rd_pend_o  (rd_pend)
  );

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Controller that owns the single write port of the general-purpose register file (32 x 32-bit, x0 hardwired to zero).
- Arbitrates write-back requests from two producers, EXU (ALU result) and LSU (load data), with round-robin fairness.
- Registers the winning write onto the GPR write port.
- Keeps a per-register pending scoreboard, so the issue stage stalls on RAW and WAW hazards against in-flight writes.

Parameters:
- GPR_ADDR_WIDTH, 5, register index width; 2**GPR_ADDR_WIDTH scoreboard entries.
- DATA_WIDTH, 32, write-back data width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- exu_wb_valid  in  1  EXU write-back request.
- exu_wb_ready  out  1  EXU request granted this cycle.
- exu_wb_rd  in  GPR_ADDR_WIDTH  EXU destination register.
- exu_wb_data  in  DATA_WIDTH  EXU result.
- lsu_wb_valid  in  1  LSU write-back request.
- lsu_wb_ready  out  1  LSU request granted this cycle.
- lsu_wb_rd  in  GPR_ADDR_WIDTH  LSU destination register.
- lsu_wb_data  in  DATA_WIDTH  LSU load data.
- issue_valid  in  1  issue stage presents an instruction.
- issue_ready  out  1  instruction may issue (no hazard).
- issue_rd_wen  in  1  instruction writes a destination register.
- issue_rd  in  GPR_ADDR_WIDTH  destination register.
- issue_rs_use  in  2  bit0 uses rs1, bit1 uses rs2; same encoding as the GPR read enables.
- issue_rs1  in  GPR_ADDR_WIDTH  source register 1.
- issue_rs2  in  GPR_ADDR_WIDTH  source register 2.
- hazard_stall  out  1  issue_valid and not issue_ready.
- gpr_wen  out  1  GPR write enable.
- gpr_waddr  out  GPR_ADDR_WIDTH  GPR write address.
- gpr_wdata  out  DATA_WIDTH  GPR write data.

Behaviour:
- Reset: rst high at a clk edge clears all pending bits, sets the round-robin pointer to EXU, and drives gpr_wen/gpr_waddr/gpr_wdata to 0. rst overrides any handshake in the same cycle, including reset mid-operation; in-flight writes are dropped.
- Arbitration (combinational, same cycle):
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester selected by the pointer wins; the other sees ready=0 and must hold valid/rd/data stable.
  - Pointer flips to the non-winner only after a contested grant; an uncontested grant leaves it unchanged.
  - Exactly zero or one ready per cycle.
- Write stage (1-cycle latency): a handshake in cycle N drives gpr_wen=1, gpr_waddr=rd, gpr_wdata=data in cycle N+1. With no handshake, gpr_wen=0 and addr/data hold.
- x0: a handshake with rd=0 is accepted, but gpr_wen stays 0 in N+1.
- Scoreboard set: on issue_valid & issue_ready & issue_rd_wen & issue_rd!=0, pending[issue_rd] sets at the edge.
- Scoreboard clear: pending[gpr_waddr] clears at the same edge the GPR captures the write (end of cycle N+1). A read issued in N+2 sees the new value.
- Same register set and cleared at one edge: set wins. This is unreachable through the WAW rule, but must still be implemented as set-wins.
- issue_ready is combinational and is 0 if any of the following holds:
  - issue_rs_use[0] and pending[issue_rs1];
  - issue_rs_use[1] and pending[issue_rs2];
  - issue_rd_wen and pending[issue_rd] (WAW).
- The pending bit for x0 is never set; x0 sources never stall.
- A producer writing a register that is not pending is legal and updates the GPR normally.

Decomposition:
- Shared package holds GPR_ADDR_WIDTH, DATA_WIDTH, the requester index constants (EXU=0, LSU=1), and the rs_use bit positions.
- One natural sub-module: gpr_scoreboard, holding the pending vector with set/clear ports and two read-lookup ports plus the WAW lookup. Arbiter and write stage stay in the top level.

Test Plan:
- Reset then idle, with rst held 2 cycles mid-run while pending[5]=1 -> gpr_wen=0 and all pending bits 0 the cycle after rst falls; issue rs1=5 is ready.
- EXU alone, rd=3, data=0xDEADBEEF -> exu_wb_ready=1 in N; in N+1 gpr_wen=1, waddr=3, wdata=0xDEADBEEF.
- Both valid for 4 cycles, pointer=EXU, distinct rds -> grants go EXU, LSU, EXU, LSU; no cycle has both ready=1.
- Issue rd=7 (wen=1) accepted, then issue rs1=7 -> hazard_stall=1 until the LSU write to 7 appears on gpr_wen; issue_ready=1 the following cycle.
- Issue with issue_rd=7 while pending[7]=1 -> issue_ready=0 (WAW); rs1=0 with rs_use=01 -> never stalls.
- LSU write with rd=0, data=0x1234 -> lsu_wb_ready=1, gpr_wen stays 0, and no pending bit changes.
